imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the ID-stage immediate sign extender: takes a base instruction word plus a 32-bit
//  immediate and imm_sel, then scatters the immediate into that format's instruction bit fields.
//  Range-checks the immediate against the format and flags values that will not decode back
//  unchanged. Two-stage valid/ready pipeline used by the instruction-injection/test-loader path.
//  Throughput 1 instr/cycle.
// PARAMETERS
//  CNT_W  16  width of the optional saturating error counter
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  in_valid   in   1   input beat valid
//  in_ready   out  1   input beat accepted when in_valid&&in_ready
//  base_inst  in   32  instruction word; non-immediate fields are kept
//  imm        in   32  immediate value to encode
//  imm_sel    in   4   [2:0] format (`IMM_TYPE1..6 from encordings.v); [3] 1=unsigned check
//  out_valid  out  1   output beat valid
//  out_ready  in   1   downstream accepts when out_valid&&out_ready
//  out_inst   out  32  encoded instruction
//  out_err    out  1   immediate out of range / misaligned / illegal imm_sel; qualifies out_inst
//  err_cnt    out  CNT_W  errored beats (only with IMM_ENC_ERR_CNT_EN)
// BEHAVIOUR
//  Reset (async, reset_n=0): both stage valids=0, out_valid=0, out_inst=0, out_err=0, err_cnt=0;
//   in_ready=1 from first clock after release. Reset mid-transfer discards all in-flight beats.
//  Field placement (immediate fields of base_inst overwritten, all other bits kept):
//   TYPE1 U: inst[31:12]=imm[31:12]; err if imm[11:0]!=0.
//   TYPE2 J signed: inst[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12];
//    err if imm[0]!=0 or imm[31:20] != {12{imm[20]}}.
//   TYPE2 unsigned: inst[31:12]=imm[20:1]; err if imm[0]!=0 or imm[31:21]!=0.
//   TYPE3 I: inst[31:20]=imm[11:0]. TYPE5 S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
//    Signed: err if imm[31:11] not all equal; unsigned: err if imm[31:12]!=0.
//   TYPE4 B: inst[31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1];
//    err if imm[0]!=0; signed err if imm[31:12] not all equal; unsigned err if imm[31:13]!=0.
//   TYPE6 shamt: inst[29:25]=imm[4:0]; err if imm[31:5]!=0 (imm_sel[3] ignored).
//   Any other imm_sel[2:0]: out_inst=base_inst unchanged, out_err=1.
//  Errored beats still emit the truncated encoding; out_err=1 alongside.
//  Pipeline: S1 registers base_inst/imm/imm_sel and computes range check; S2 holds out_inst/out_err.
//   Latency 2 cycles from accept to out_valid with out_ready held 1.
//  Handshake: out_* stable while out_valid&&!out_ready. in_ready = !s1_valid || (!s2_valid || out_ready)
//   (S1 frees when S1 can move into S2). No combinational path in_valid->out_valid.
//  Simultaneous: full pipe with out_ready=1 and in_valid=1: S2 pops, S1->S2, new beat->S1, same cycle.
//   Full pipe with out_ready=0: in_ready=0; no beat is lost or duplicated.
// CONFIGURATION
//  IMM_ENC_ERR_CNT_EN defined: err_cnt port present; increments by 1 on each out_valid&&out_ready
//   beat with out_err=1; saturates at all-ones (no wrap); cleared only by reset.
//  Not defined: err_cnt port and counter logic absent; all other behaviour identical.
// TESTING
//  I signed: base=32'h0000_0013, imm=-1, sel=TYPE3 -> out_inst=32'hFFF0_0013, err=0, 2 cycles later.
//  S range: imm=32'h0000_0800 signed TYPE5 -> err=1; same imm unsigned TYPE5 -> err=0,
//   inst[31:25]=7'h40, inst[11:7]=0.
//  B: imm=32'hFFFF_F000 (-4096) signed TYPE4 -> inst[31]=1, [7]=0, [30:25]=0, [11:8]=0, err=0;
//   imm=3 -> err=1 (misaligned).
//  Backpressure: 4 back-to-back beats, out_ready=0 for 5 cycles -> in_ready drops after 2 accepts,
//   out_* stable; then out_ready=1 -> 4 beats in order, no loss/duplication.
//  Reset mid-stream: reset_n low with 2 beats in flight -> out_valid=0 immediately; no stale beat
//   after release; err_cnt=0.
//  Round-trip: random imm/sel through imm_encoder then sign_extender -> decoded==imm whenever err=0;
//   with IMM_ENC_ERR_CNT_EN, err_cnt equals count of errored accepted beats, saturating at 16'hFFFF.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 32-bit immediate into the immediate fields of a base instruction word,
// flagging values that would not decode back unchanged. Optional macro: IMM_ENC_ERR_CNT_EN (err_cnt).
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      base_inst,
    input  logic [31:0]      imm,
    input  logic [3:0]       imm_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err
`ifdef IMM_ENC_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam logic [2:0] IMM_TYPE1 = 3'd1;
    localparam logic [2:0] IMM_TYPE2 = 3'd2;
    localparam logic [2:0] IMM_TYPE3 = 3'd3;
    localparam logic [2:0] IMM_TYPE4 = 3'd4;
    localparam logic [2:0] IMM_TYPE5 = 3'd5;
    localparam logic [2:0] IMM_TYPE6 = 3'd6;

    logic        r_s1Valid;
    logic [31:0] r_s1Base;
    logic [31:0] r_s1Imm;
    logic [3:0]  r_s1Sel;
    logic        r_s2Valid;
    logic [31:0] r_outInst;
    logic        r_outErr;

    logic        w_accept;
    logic        w_s1Move;
    logic        w_fits12s;
    logic        w_fits13s;
    logic        w_fits21s;
    logic [31:0] w_encInst;
    logic        w_encErr;

    // S1 may advance whenever S2 is empty or is being drained this cycle.
    assign w_s1Move  = r_s1Valid && (!r_s2Valid || out_ready);
    assign in_ready  = !r_s1Valid || !r_s2Valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_s2Valid;
    assign out_inst  = r_outInst;
    assign out_err   = r_outErr;

    // Signed-range checks: the bits above the field's sign bit must all replicate it.
    assign w_fits12s = (r_s1Imm[31:11] == {21{r_s1Imm[11]}});
    assign w_fits13s = (r_s1Imm[31:12] == {20{r_s1Imm[12]}});
    assign w_fits21s = (r_s1Imm[31:20] == {12{r_s1Imm[20]}});

    always_comb begin
        w_encInst = r_s1Base;
        w_encErr  = 1'b0;
        case (r_s1Sel[2:0])
            IMM_TYPE1: begin
                w_encInst[31:12] = r_s1Imm[31:12];
                w_encErr         = |r_s1Imm[11:0];
            end
            IMM_TYPE2: begin
                if (r_s1Sel[3]) begin
                    w_encInst[31:12] = r_s1Imm[20:1];
                    w_encErr         = r_s1Imm[0] || (|r_s1Imm[31:21]);
                end else begin
                    w_encInst[31]    = r_s1Imm[20];
                    w_encInst[30:21] = r_s1Imm[10:1];
                    w_encInst[20]    = r_s1Imm[11];
                    w_encInst[19:12] = r_s1Imm[19:12];
                    w_encErr         = r_s1Imm[0] || !w_fits21s;
                end
            end
            IMM_TYPE3: begin
                w_encInst[31:20] = r_s1Imm[11:0];
                w_encErr         = r_s1Sel[3] ? (|r_s1Imm[31:12]) : !w_fits12s;
            end
            IMM_TYPE4: begin
                w_encInst[31]    = r_s1Imm[12];
                w_encInst[7]     = r_s1Imm[11];
                w_encInst[30:25] = r_s1Imm[10:5];
                w_encInst[11:8]  = r_s1Imm[4:1];
                w_encErr         = r_s1Imm[0] || (r_s1Sel[3] ? (|r_s1Imm[31:13]) : !w_fits13s);
            end
            IMM_TYPE5: begin
                w_encInst[31:25] = r_s1Imm[11:5];
                w_encInst[11:7]  = r_s1Imm[4:0];
                w_encErr         = r_s1Sel[3] ? (|r_s1Imm[31:12]) : !w_fits12s;
            end
            IMM_TYPE6: begin
                w_encInst[29:25] = r_s1Imm[4:0];
                w_encErr         = |r_s1Imm[31:5];
            end
            default: begin
                w_encErr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
            r_s1Base  <= '0;
            r_s1Imm   <= '0;
            r_s1Sel   <= '0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1Base  <= base_inst;
            r_s1Imm   <= imm;
            r_s1Sel   <= imm_sel;
        end else if (w_s1Move) begin
            r_s1Valid <= 1'b0;
        end
    end

    // S2 holds its beat untouched until the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2Valid <= 1'b0;
            r_outInst <= '0;
            r_outErr  <= 1'b0;
        end else if (w_s1Move) begin
            r_s2Valid <= 1'b1;
            r_outInst <= w_encInst;
            r_outErr  <= w_encErr;
        end else if (out_ready) begin
            r_s2Valid <= 1'b0;
        end
    end

`ifdef IMM_ENC_ERR_CNT_EN
    logic [CNT_W-1:0] r_errCnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_errCnt <= '0;
        end else if (r_s2Valid && out_ready && r_outErr && (r_errCnt != {CNT_W{1'b1}})) begin
            r_errCnt <= r_errCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_cnt = r_errCnt;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against a range/field model
// and a sign-extender style decoder; honours IMM_ENC_ERR_CNT_EN when defined.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] base_inst = '0;
    logic [31:0] imm = '0;
    logic [3:0]  imm_sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
`ifdef IMM_ENC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int testsRun = 0;
    int failCount = 0;
    int acceptCount = 0;
    int popCount = 0;
    int errModel = 0;
    bit monEn = 1'b0;

    logic [32:0] expQ[$];
    logic [35:0] rtQ[$];
    logic [31:0] lastInst = '0;
    logic        lastErr = 1'b0;
    logic        holdValid = 1'b0;
    logic [32:0] holdVal = '0;
    logic [32:0] expVal;
    logic [35:0] rtVal;
    int          occ;

    imm_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base_inst (base_inst),
        .imm       (imm),
        .imm_sel   (imm_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err)
`ifdef IMM_ENC_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit inRange(int v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Expected {err, inst} from the placement table and numeric range of each format.
    function automatic logic [32:0] modelEncode(logic [31:0] b, logic [31:0] v, logic [3:0] s);
        int          sv;
        logic [31:0] inst;
        bit          e;
        sv   = $signed(v);
        inst = b;
        e    = 1'b0;
        case (s[2:0])
            3'd1: begin
                inst = (b & 32'h0000_0FFF) | (v & 32'hFFFF_F000);
                e    = (v % 4096) != 0;
            end
            3'd2: begin
                inst = b & 32'h0000_0FFF;
                if (s[3]) begin
                    inst = inst | (((v >> 1) & 32'h000F_FFFF) << 12);
                    e    = v[0] || (v >= 32'h0020_0000);
                end else begin
                    inst = inst | (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                                | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12);
                    e    = v[0] || !inRange(sv, -(1 << 20), (1 << 20) - 1);
                end
            end
            3'd3: begin
                inst = (b & 32'h000F_FFFF) | ((v & 32'hFFF) << 20);
                e    = s[3] ? (v >= 32'd4096) : !inRange(sv, -2048, 2047);
            end
            3'd4: begin
                inst = (b & 32'h01FF_F07F) | (((v >> 12) & 32'h1) << 31) | (((v >> 11) & 32'h1) << 7)
                                           | (((v >> 5) & 32'h3F) << 25) | (((v >> 1) & 32'hF) << 8);
                e    = v[0] || (s[3] ? (v >= 32'd8192) : !inRange(sv, -4096, 4095));
            end
            3'd5: begin
                inst = (b & 32'h01FF_F07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
                e    = s[3] ? (v >= 32'd4096) : !inRange(sv, -2048, 2047);
            end
            3'd6: begin
                inst = (b & 32'hC1FF_FFFF) | ((v & 32'h1F) << 25);
                e    = v >= 32'd32;
            end
            default: e = 1'b1;
        endcase
        return {e, inst};
    endfunction

    function automatic logic [31:0] sext(int f, int w);
        if (((f >> (w - 1)) & 1) != 0) return 32'(f - (1 << w));
        return 32'(f);
    endfunction

    // Decoder in the style of the ID-stage sign extender.
    function automatic logic [31:0] decodeImm(logic [31:0] inst, logic [3:0] s);
        int f;
        case (s[2:0])
            3'd1: return inst & 32'hFFFF_F000;
            3'd2: begin
                if (s[3]) return {11'b0, inst[31:12], 1'b0};
                f = int'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
                return sext(f, 21);
            end
            3'd3: begin
                f = int'(inst[31:20]);
                return s[3] ? 32'(f) : sext(f, 12);
            end
            3'd4: begin
                f = int'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
                return s[3] ? 32'(f) : sext(f, 13);
            end
            3'd5: begin
                f = int'({inst[31:25], inst[11:7]});
                return s[3] ? 32'(f) : sext(f, 12);
            end
            3'd6: return {27'b0, inst[29:25]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] genImm();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return 32'($urandom_range(0, 16383));
            3: return 32'($urandom_range(0, 40));
            4: return $urandom & 32'hFFFF_F000;
            default: return (32'($urandom_range(0, 32'h0040_0000)) - 32'h0020_0000) & ~32'h1;
        endcase
    endfunction

    // Scoreboard: handshakes are judged at the negedge, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (monEn && reset_n) begin
            occ = expQ.size();
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (occ < 2) || out_ready});
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_beat", 32'd1, 32'd0);
                end else begin
                    expVal = expQ.pop_front();
                    rtVal  = rtQ.pop_front();
                    checkOutput("out_inst", out_inst, expVal[31:0]);
                    checkOutput("out_err", {31'b0, out_err}, {31'b0, expVal[32]});
                    if (!out_err && !expVal[32])
                        checkOutput("roundtrip", decodeImm(out_inst, rtVal[35:32]), rtVal[31:0]);
                    if (out_err) errModel++;
                    lastInst = out_inst;
                    lastErr  = out_err;
                    popCount++;
                end
                holdValid = 1'b0;
            end else if (out_valid) begin
                if (holdValid) begin
                    checkOutput("hold_inst", out_inst, holdVal[31:0]);
                    checkOutput("hold_err", {31'b0, out_err}, {31'b0, holdVal[32]});
                end
                holdValid = 1'b1;
                holdVal   = {out_err, out_inst};
            end else begin
                holdValid = 1'b0;
            end
            if (in_valid && in_ready) begin
                expQ.push_back(modelEncode(base_inst, imm, imm_sel));
                rtQ.push_back({imm_sel, imm});
                acceptCount++;
            end
        end
    end

    task automatic clearModel();
        expQ.delete();
        rtQ.delete();
        holdValid = 1'b0;
        errModel  = 0;
    endtask

    task automatic doReset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clearModel();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_inst", out_inst, 32'd0);
        checkOutput("rst_out_err", {31'b0, out_err}, 32'd0);
`ifdef IMM_ENC_ERR_CNT_EN
        checkOutput("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
`endif
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] b, input logic [31:0] i, input logic [3:0] s, input int budget);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        base_inst = b;
        imm       = i;
        imm_sel   = s;
        in_valid  = 1'b1;
        while (!acc && n < budget) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitPops(input int target, input int budget);
        int n;
        n = 0;
        while (popCount < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (popCount < target) checkOutput("pop_timeout", 32'(popCount), 32'(target));
    endtask

    initial begin
        int base;
        monEn = 1'b1;
        doReset();
        checkOutput("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // I-type signed with latency check
        out_ready = 1'b1;
        applyStimulus(32'h0000_0013, 32'hFFFF_FFFF, 4'd3, 10);
        checkOutput("lat_s1", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_s2", {31'b0, out_valid}, 32'd1);
        checkOutput("I_inst", out_inst, 32'hFFF0_0013);
        checkOutput("I_err", {31'b0, out_err}, 32'd0);
        waitPops(1, 10);

        // S-type range: signed overflows, unsigned fits
        applyStimulus(32'h0, 32'h0000_0800, 4'd5, 10);
        waitPops(2, 10);
        checkOutput("S_signed_err", {31'b0, lastErr}, 32'd1);
        applyStimulus(32'h0, 32'h0000_0800, 4'd13, 10);
        waitPops(3, 10);
        checkOutput("S_uns_err", {31'b0, lastErr}, 32'd0);
        checkOutput("S_uns_hi", {25'b0, lastInst[31:25]}, 32'h40);
        checkOutput("S_uns_lo", {27'b0, lastInst[11:7]}, 32'h0);

        // B-type most-negative offset and misaligned offset
        applyStimulus(32'h0, 32'hFFFF_F000, 4'd4, 10);
        waitPops(4, 10);
        checkOutput("B_inst", lastInst, 32'h8000_0000);
        checkOutput("B_err", {31'b0, lastErr}, 32'd0);
        applyStimulus(32'h0, 32'h3, 4'd4, 10);
        waitPops(5, 10);
        checkOutput("B_misalign", {31'b0, lastErr}, 32'd1);

        // Backpressure: only two beats fit while the consumer stalls
        out_ready = 1'b0;
        base = acceptCount;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    applyStimulus($urandom, genImm(), 4'($urandom_range(0, 15)), 30);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                checkOutput("bp_accepts", 32'(acceptCount - base), 32'd2);
                checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
                checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
                out_ready = 1'b1;
            end
        join
        waitPops(9, 20);

        // Reset with two beats in flight
        out_ready = 1'b0;
        applyStimulus(32'h1234_5678, 32'h10, 4'd3, 10);
        applyStimulus(32'h8765_4321, 32'h20, 4'd3, 10);
        #2 reset_n = 1'b0;
        clearModel();
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef IMM_ENC_ERR_CNT_EN
        checkOutput("midrst_err_cnt", {16'b0, err_cnt}, 32'd0);
`endif
        @(posedge clk);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            checkOutput("no_stale_beat", {31'b0, out_valid}, 32'd0);
        end

        // Randomized traffic with random backpressure
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            base_inst = $urandom;
            imm       = genImm();
            imm_sel   = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
`ifdef IMM_ENC_ERR_CNT_EN
        checkOutput("err_cnt", {16'b0, err_cnt}, 32'(errModel));
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
